// File: rtl/chaos_pkg.sv
// Shared types and FP32 field constants for the chaos keystream extractor.
package chaos_pkg;

  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam logic [7:0] EXP_ZERO = 8'h00;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  typedef logic [15:0] key_word_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } ser_state_t;

  // Zero/denormal or inf/NaN exponent marks a collapsed or diverged orbit.
  function automatic logic is_degenerate(input logic [31:0] v);
    logic [7:0] e;
    e = v[EXP_MSB:EXP_LSB];
    return (e == EXP_ZERO) || (e == EXP_MAX);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/chaos_word_fifo.sv
// Synchronous show-ahead FIFO of 16-bit key words; full push and empty pop are ignored.
module chaos_word_fifo
  import chaos_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  key_word_t                wdata,
  output key_word_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  key_word_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chaos_key_extractor.sv
// Turns chaotic FP32 state triples into a byte-wide keystream: warm-up discard,
// degenerate-sample rejection, 16-bit folding, word FIFO and lo/hi serializer.
module chaos_key_extractor
  import chaos_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DISCARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1_in,
  input  logic [31:0] x2_in,
  input  logic [31:0] x3_in,
  output logic [7:0]  key_byte,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        warm_done,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  key_word_t   fifo_rdata;
  key_word_t   fold_word;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        accept;
  logic        degen;
  logic        push;
  logic        pop;
  logic [15:0] warm_cnt;
  logic [7:0]  hi_byte_q;
  ser_state_t  state;

  // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign warm_done = (warm_cnt == 16'(DISCARD));
  assign degen     = is_degenerate(x1_in) || is_degenerate(x2_in) || is_degenerate(x3_in);
  assign fold_word = x1_in[15:0] ^ x2_in[15:0] ^ x3_in[15:0];
  assign push      = accept && warm_done && !degen;

  chaos_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fold_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
      bad_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && !warm_done)         warm_cnt <= warm_cnt + 16'd1;
      if (accept && warm_done && degen) bad_cnt  <= sat_inc(bad_cnt);
      if (in_valid && !in_ready)        drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // NOTE: combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      ST_EMPTY: pop = !fifo_empty;
      ST_HI:    pop = key_ready && !fifo_empty;
      default:  pop = 1'b0;
    endcase
  end

  // Only the high byte needs holding; the low byte goes straight into key_byte on pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      hi_byte_q <= '0;
      key_byte  <= '0;
      key_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (pop) begin
            hi_byte_q <= fifo_rdata[15:8];
            key_byte  <= fifo_rdata[7:0];
            key_valid <= 1'b1;
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (key_ready) begin
            key_byte <= hi_byte_q;
            state    <= ST_HI;
          end
        end
        ST_HI: begin
          if (key_ready) begin
            if (pop) begin
              hi_byte_q <= fifo_rdata[15:8];
              key_byte  <= fifo_rdata[7:0];
              state     <= ST_LO;
            end else begin
              key_valid <= 1'b0;
              state     <= ST_EMPTY;
            end
          end
        end
        default: begin
          key_valid <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

  occupancy_bounded: assert property (@(posedge clk) disable iff (!rst)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_chaos_key_extractor.sv
// Randomized bench for chaos_key_extractor against a queue-based keystream model.
module tb_chaos_key_extractor;

  localparam int DEPTH   = 8;
  localparam int DISCARD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2, x3;
  logic [7:0]  key_byte;
  logic        key_valid;
  logic        key_ready;
  logic        warm_done;
  logic [15:0] bad_cnt;
  logic [15:0] drop_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // Model: words waiting, word being sent and how many of its bytes remain.
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  int          m_rem;
  int          m_warm;
  int          m_bad;
  int          m_drop;

  chaos_key_extractor #(.DEPTH(DEPTH), .DISCARD(DISCARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1_in     (x1),
    .x2_in     (x2),
    .x3_in     (x3),
    .key_byte  (key_byte),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .warm_done (warm_done),
    .bad_cnt   (bad_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rand_fp(input bit bad);
    logic [31:0] v;
    v = $urandom;
    if (bad) v[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    else     v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  function automatic bit sample_bad(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [7:0] ea, eb, ec;
    ea = a[30:23]; eb = b[30:23]; ec = c[30:23];
    return ea == 8'h00 || ea == 8'hFF || eb == 8'h00 || eb == 8'hFF || ec == 8'h00 || ec == 8'hFF;
  endfunction

  function automatic logic [7:0] exp_byte();
    return (m_rem == 2) ? m_cur[7:0] : m_cur[15:8];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur  = '0;
    m_rem  = 0;
    m_warm = 0;
    m_bad  = 0;
    m_drop = 0;
  endtask

  // Advance one clock, moving the model by the same input values the DUT sees.
  task automatic step();
    bit rdy;
    bit had_word;
    rdy      = m_q.size() < DEPTH;
    had_word = m_q.size() > 0;
    @(posedge clk);
    if (m_rem == 0) begin
      if (had_word) begin m_cur = m_q.pop_front(); m_rem = 2; end
    end else if (key_ready) begin
      if (m_rem == 2)    m_rem = 1;
      else if (had_word) begin m_cur = m_q.pop_front(); m_rem = 2; end
      else               m_rem = 0;
    end
    if (in_valid && rdy) begin
      if (m_warm < DISCARD)            m_warm++;
      else if (sample_bad(x1, x2, x3)) begin if (m_bad < 65535) m_bad++; end
      else                             m_q.push_back(x1[15:0] ^ x2[15:0] ^ x3[15:0]);
    end else if (in_valid) begin
      if (m_drop < 65535) m_drop++;
    end
    #1;
  endtask

  task automatic set_ref_sample();
    x1 = 32'h3F80_1234;
    x2 = 32'h3F80_00FF;
    x3 = 32'h4000_0F00;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; key_ready = 1'b0;
    x1 = '0; x2 = '0; x3 = '0;
    model_reset();
    #1;
    n_total++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready got=%b exp=1", in_ready);   else n_pass++;
    n_total++; if (key_valid !== 1'b0)  $display("FAIL reset_key_valid got=%b exp=0", key_valid); else n_pass++;
    n_total++; if (key_byte !== 8'h00)  $display("FAIL reset_key_byte got=%h exp=00", key_byte);  else n_pass++;
    n_total++; if (warm_done !== 1'b0)  $display("FAIL reset_warm_done got=%b exp=0", warm_done); else n_pass++;
    n_total++; if (bad_cnt !== 16'h0)   $display("FAIL reset_bad_cnt got=%h exp=0", bad_cnt);     else n_pass++;
    n_total++; if (drop_cnt !== 16'h0)  $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt);   else n_pass++;
    #2 rst = 1'b1;
  endtask

  task automatic test_warmup();
    key_ready = 1'b1; in_valid = 1'b1;
    set_ref_sample();
    step();
    n_total++; if (warm_done !== 1'b0) $display("FAIL warm_after1 got=%b exp=0", warm_done); else n_pass++;
    step();
    n_total++; if (warm_done !== 1'b1) $display("FAIL warm_after2 got=%b exp=1", warm_done); else n_pass++;
    n_total++; if (key_valid !== 1'b0) $display("FAIL warm_swallow got=%b exp=0", key_valid); else n_pass++;
    step();
    n_total++; if (key_valid !== 1'b0) $display("FAIL lat_accept_edge got=%b exp=0", key_valid); else n_pass++;
    in_valid = 1'b0;
    step();
    n_total++; if (key_valid !== 1'b1) $display("FAIL lat_lo_valid got=%b exp=1", key_valid); else n_pass++;
    n_total++; if (key_byte !== 8'hCB) $display("FAIL lat_lo_byte got=%h exp=cb", key_byte); else n_pass++;
    step();
    n_total++; if (key_byte !== 8'h1D || key_valid !== 1'b1)
      $display("FAIL hi_byte got=%h/%b exp=1d/1", key_byte, key_valid); else n_pass++;
    step();
    n_total++; if (key_valid !== 1'b0) $display("FAIL after_word got=%b exp=0", key_valid); else n_pass++;
  endtask

  task automatic test_degenerate();
    key_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_ref_sample();
      if (k == 0) x3 = 32'h0000_0000;
      else        x1 = 32'h7FC0_0000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        n_total++; if (key_valid !== 1'b0) $display("FAIL degen_no_output k=%0d got=%b exp=0", k, key_valid); else n_pass++;
      end
      n_total++; if (bad_cnt !== 16'(k + 1)) $display("FAIL degen_bad_cnt got=%0d exp=%0d", bad_cnt, k + 1); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    key_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      x1 = rand_fp(0); x2 = rand_fp(0); x3 = rand_fp(0);
      step();
      n_total++; if (in_ready !== (m_q.size() < DEPTH))
        $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, m_q.size() < DEPTH); else n_pass++;
      n_total++; if (drop_cnt !== 16'(m_drop))
        $display("FAIL bp_drop_cnt c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); else n_pass++;
      n_total++; if (key_valid !== 1'b1 && c > 0)
        $display("FAIL bp_key_valid c=%0d got=%b exp=1", c, key_valid); else n_pass++;
    end
    n_total++; if (drop_cnt !== 16'd5) $display("FAIL bp_drop_total got=%0d exp=5", drop_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b0)  $display("FAIL bp_full_ready got=%b exp=0", in_ready); else n_pass++;
    in_valid = 1'b0; key_ready = 1'b1;
    for (int c = 0; c < 40 && (m_rem != 0 || m_q.size() != 0); c++) begin
      step();
      n_total++; if (key_valid !== (m_rem != 0) || (m_rem != 0 && key_byte !== exp_byte()))
        $display("FAIL bp_drain c=%0d got=%b/%h exp=%b/%h", c, key_valid, key_byte, m_rem != 0, exp_byte()); else n_pass++;
    end
    n_total++; if (key_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", key_valid); else n_pass++;
  endtask

  task automatic test_stall_toggle();
    logic [7:0] got[$];
    logic [7:0] exp[$];
    bit         was_stalled;
    logic [7:0] held;
    was_stalled = 1'b0; held = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (c < 4);
      key_ready = c[0];
      if (in_valid) begin
        x1 = rand_fp(0); x2 = rand_fp(0); x3 = rand_fp(0);
        exp.push_back(x1[7:0] ^ x2[7:0] ^ x3[7:0]);
        exp.push_back(x1[15:8] ^ x2[15:8] ^ x3[15:8]);
      end
      if (key_valid && key_ready) got.push_back(key_byte);
      was_stalled = key_valid && !key_ready;
      held        = key_byte;
      step();
      if (was_stalled) begin
        n_total++; if (key_valid !== 1'b1 || key_byte !== held)
          $display("FAIL stall_stable c=%0d got=%b/%h exp=1/%h", c, key_valid, key_byte, held); else n_pass++;
      end
    end
    n_total++; if (got.size() != 8) $display("FAIL stall_byte_count got=%0d exp=8", got.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_total++; if (got[i] !== exp[i]) $display("FAIL stall_order i=%0d got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      key_ready = ($urandom_range(0, 3) != 0);
      x1 = rand_fp($urandom_range(0, 15) == 0);
      x2 = rand_fp($urandom_range(0, 15) == 0);
      x3 = rand_fp(0);
      step();
      n_total++; if (in_ready !== (m_q.size() < DEPTH))
        $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, m_q.size() < DEPTH); else n_pass++;
      n_total++; if (key_valid !== (m_rem != 0))
        $display("FAIL rand_key_valid c=%0d got=%b exp=%b", c, key_valid, m_rem != 0); else n_pass++;
      if (m_rem != 0) begin
        n_total++; if (key_byte !== exp_byte())
          $display("FAIL rand_key_byte c=%0d got=%h exp=%h", c, key_byte, exp_byte()); else n_pass++;
      end
      n_total++; if (bad_cnt !== 16'(m_bad) || drop_cnt !== 16'(m_drop))
        $display("FAIL rand_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, bad_cnt, drop_cnt, m_bad, m_drop); else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b0; key_ready = 1'b1;
    for (int c = 0; c < 40 && (m_rem != 0 || m_q.size() != 0); c++) step();
    key_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      x1 = rand_fp(0); x2 = rand_fp(0); x3 = rand_fp(0);
      step();
    end
    n_total++; if (key_valid !== 1'b1 || m_q.size() != 5)
      $display("FAIL mid_prefill got=%b q=%0d exp=1 q=5", key_valid, m_q.size()); else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_total++; if (key_valid !== 1'b0) $display("FAIL mid_key_valid got=%b exp=0", key_valid); else n_pass++;
    n_total++; if (bad_cnt !== 16'h0 || drop_cnt !== 16'h0)
      $display("FAIL mid_counters got=%0d/%0d exp=0/0", bad_cnt, drop_cnt); else n_pass++;
    n_total++; if (warm_done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_warm_ready got=%b/%b exp=0/1", warm_done, in_ready); else n_pass++;
    model_reset();
    #1 rst = 1'b1;
    key_ready = 1'b1;
    set_ref_sample();
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++; if (key_valid !== 1'b0) $display("FAIL mid_rewarm c=%0d got=%b exp=0", c, key_valid); else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_total++; if (key_valid !== 1'b1 || key_byte !== 8'hCB)
      $display("FAIL mid_first_out got=%b/%h exp=1/cb", key_valid, key_byte); else n_pass++;
    step();
    step();
  endtask

  task automatic test_bad_saturate();
    in_valid = 1'b1; key_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      x1 = rand_fp(1); x2 = rand_fp(0); x3 = rand_fp(0);
      step();
      if (i % 8192 == 0 || i >= 65533) begin
        n_total++; if (bad_cnt !== 16'(m_bad))
          $display("FAIL sat_bad_cnt i=%0d got=%h exp=%h", i, bad_cnt, 16'(m_bad)); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (bad_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", bad_cnt); else n_pass++;
    n_total++; if (key_valid !== 1'b0) $display("FAIL sat_no_output got=%b exp=0", key_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_degenerate();
    test_backpressure();
    test_stall_toggle();
    test_random();
    test_reset_midstream();
    test_bad_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
